// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter with fixed-length burst tracking.
// Locked transfers are compiled in only when AHB_ARB_LOCK_EN is defined.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           clock,
  input  logic                           Hreset,
  input  logic [NUM_MASTERS-1:0]         Hbusreq,
  input  logic [NUM_MASTERS-1:0]         Hlock,
  input  logic [1:0]                     Htrans,
  input  logic [2:0]                     Hburst,
  input  logic                           Hreadyout,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster,
  output logic                           Hmastlock
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] GRANT_DEF =
    NUM_MASTERS'(1) << DEFAULT_MASTER;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    PARK,
    OWN,
    BURST,
    LOCK
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [MW-1:0]          master_q, master_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   mlock_q, mlock_d;

  logic [MW-1:0] gidx;
  logic [MW-1:0] win_idx;
  logic [MW-1:0] cand;
  logic          win_vld;
  logic [3:0]    burst_len;
  logic          burst_start;
  logic          lock_req;
  logic          do_arb;

  // Scan from ptr+1 downward in priority so the nearest requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = MW'((int'(ptr_q) + i) % NUM_MASTERS);
      if (Hbusreq[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) gidx = MW'(i);
    end
  end

  always_comb begin
    unique case (Hburst[2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      2'b11:   burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  end

  assign burst_start = (Htrans == T_NONSEQ) &&
                       (Hburst[2:1] != 2'b00);

`ifdef AHB_ARB_LOCK_EN
  assign lock_req = Hlock[gidx];
`else
  logic unused_lock;
  assign unused_lock = ^Hlock;
  assign lock_req    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    master_d = master_q;
    mlock_d  = mlock_q;
    do_arb   = 1'b0;
    if (Hreadyout) begin
      master_d = gidx;
      unique case (state_q)
        PARK: do_arb = 1'b1;
        OWN: begin
          if (lock_req) begin
            state_d = LOCK;
          end else if (burst_start) begin
            state_d = BURST;
            cnt_d   = burst_len;
          end else begin
            do_arb = 1'b1;
          end
        end
        BURST: begin
          unique case (Htrans)
            T_SEQ: begin
              if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
              else              do_arb = 1'b1;
            end
            T_BUSY: ;
            T_NONSEQ: begin
              if (burst_start) cnt_d = burst_len;
              else             do_arb = 1'b1;
            end
            default: do_arb = 1'b1;
          endcase
        end
        LOCK: begin
          if (!lock_req && Htrans != T_BUSY) do_arb = 1'b1;
        end
        default: do_arb = 1'b1;
      endcase
      if (do_arb) begin
        cnt_d = '0;
        if (win_vld) begin
          state_d = OWN;
          grant_d = NUM_MASTERS'(1) << win_idx;
          ptr_d   = win_idx;
        end else begin
          state_d = PARK;
          grant_d = GRANT_DEF;
        end
      end
      mlock_d = (state_d == LOCK);
    end
  end

  always_ff @(posedge clock or posedge Hreset) begin
    if (Hreset) begin
      state_q  <= PARK;
      cnt_q    <= '0;
      ptr_q    <= MW'(DEFAULT_MASTER);
      grant_q  <= GRANT_DEF;
      master_q <= MW'(DEFAULT_MASTER);
      mlock_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = master_q;
  assign Hmastlock = mlock_q;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of AHB masters sharing the bus into the bridge (fixed at 4 in this release).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, master index parked on the bus when nobody requests.
REQ-003 clock  in  1  single clock; all state on posedge.
REQ-004 Hreset  in  1  asynchronous reset, active-high.
REQ-005 Hbusreq  in  4  per-master bus request, bit i = master i.
REQ-006 Hlock  in  4  per-master locked-transfer request.
REQ-007 Htrans  in  2  transfer type of current bus owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 Hburst  in  3  burst type of current owner: 000 SINGLE, 001 INCR, 010/011 4-beat, 100/101 8-beat, 110/111 16-beat.
REQ-009 Hreadyout  in  1  bridge transfer-done; state advances only when high.
REQ-010 Hgrant  out  4  one-hot grant, registered.
REQ-011 Hmaster  out  2  index of master owning the current address phase, registered.
REQ-012 Hmastlock  out  1  current address phase is locked, registered.

Function
REQ-013 State machine SHALL have states PARK, OWN, BURST, LOCK.
REQ-014 Any register update SHALL happen only on a posedge with Hreadyout=1; with Hreadyout=0 all outputs, state, counter and priority pointer SHALL hold.
REQ-015 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 4; first master with Hbusreq=1 wins.
REQ-016 PARK: no Hbusreq set; Hgrant one-hot DEFAULT_MASTER; any request -> OWN with arbitrated grant on next qualifying edge.
REQ-017 OWN: re-arbitration allowed every qualifying edge; granted master dropping Hbusreq -> next requester, or PARK if none.
REQ-018 OWN -> BURST when Htrans=NONSEQ with a fixed-length Hburst (010..111); beat counter loads length-1 (3, 7 or 15).
REQ-019 BURST: each edge with Htrans=SEQ decrements counter; BUSY holds counter; grant frozen while counter > 1.
REQ-020 BURST: when counter=1 and Htrans=SEQ, arbitration SHALL run on that edge so the new owner drives the cycle after the last address phase; state -> OWN or PARK.
REQ-021 Early termination: IDLE or NONSEQ seen in BURST with counter > 0 SHALL clear counter and return to OWN; a NONSEQ re-enters BURST per REQ-018.
REQ-022 SINGLE and INCR (000/001) SHALL NOT enter BURST; INCR owner is released only via Hbusreq deassert.
REQ-023 Hmaster SHALL take the index of the current Hgrant on each qualifying edge (one-cycle address-phase lag behind grant).
REQ-024 Hgrant SHALL be exactly one-hot in every cycle after reset.
REQ-025 Simultaneous requests SHALL resolve by REQ-015 only; no fixed priority.

Reset
REQ-026 Hreset=1 SHALL immediately force state PARK, Hgrant=one-hot(DEFAULT_MASTER) (0001), Hmaster=DEFAULT_MASTER, Hmastlock=0, counter=0, pointer=DEFAULT_MASTER, independent of clock.
REQ-027 Reset asserted mid-burst or mid-lock SHALL abandon the burst/lock; first edge after release behaves as from PARK.

Configuration
REQ-028 Macro AHB_ARB_LOCK_EN: when defined, OWN -> LOCK if granted master has Hlock=1 at a qualifying edge; LOCK holds grant regardless of other requests until that master drops Hlock and an address phase with Htrans!=BUSY completes; Hmastlock=1 follows Hmaster timing.
REQ-029 Without AHB_ARB_LOCK_EN: Hlock ignored, LOCK unreachable, Hmastlock constant 0.

Verification
REQ-030 Reset: Hreset pulse mid-clock -> Hgrant=0001, Hmaster=0, Hmastlock=0 before next edge.
REQ-031 Hbusreq=1111 held, Htrans=NONSEQ, Hburst=SINGLE, Hreadyout=1 -> Hgrant 0010,0100,1000,0001 on successive edges; Hmaster trails by one cycle.
REQ-032 Master 1 granted, INCR4 (NONSEQ,SEQ,SEQ,SEQ), master 2 requesting -> Hgrant stays 0010 through 3rd SEQ edge, becomes 0100 on 4th-beat edge.
REQ-033 Same INCR4 with Hreadyout=0 for 2 cycles at beat 2 -> grant, counter, Hmaster frozen; handover delayed exactly 2 cycles.
REQ-034 INCR8 terminated by IDLE after beat 3, master 3 requesting -> grant 1000 on that edge.
REQ-035 AHB_ARB_LOCK_EN defined, master 0 Hlock=1, Hbusreq=1111 -> Hgrant=0001 and Hmastlock=1 until Hlock drops; undefined -> round-robin as REQ-031, Hmastlock=0.
